uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_tx_fifo_if.sv | 24 ++
 rtl/uart_fifo_mem.sv | 18 +
 rtl/uart_tx_fifo.sv | 78 +++++++
 tb/tb_uart_tx_fifo.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: drain FSM state encoding and default FIFO depth shared by the uart_tx_fifo slice.
package uart_pkg;
  localparam int DEFAULT_DEPTH = 16;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_e;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: write side, FIFO status and transmitter handshake of uart_tx_fifo.
// ovf/ovf_clr exist only when UART_TX_FIFO_OVF_EN is defined.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(parameter int DEPTH = DEFAULT_DEPTH);
  localparam int AW = $clog2(DEPTH);
  logic          wr;
  logic [7:0]    wdata;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_rdy;
`ifdef UART_TX_FIFO_OVF_EN
  logic          ovf;
  logic          ovf_clr;
  modport slave (input wr, wdata, tx_rdy, ovf_clr, output full, empty, level, tx_start, tx_data, ovf);
  modport master (output wr, wdata, tx_rdy, ovf_clr, input full, empty, level, tx_start, tx_data, ovf);
`else
  modport slave (input wr, wdata, tx_rdy, output full, empty, level, tx_start, tx_data);
  modport master (output wr, wdata, tx_rdy, input full, empty, level, tx_start, tx_data);
`endif
endinterface

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: simple dual-port byte array, synchronous write and combinational read.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO draining into a UART transmitter through a one-cycle tx_start pulse.
// Define UART_TX_FIFO_OVF_EN to add the sticky ovf flag for writes dropped while full.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_fifo_if.slave   bus
);
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  state_e      state_q, state_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d, rdata;
  logic        full, empty, push, pop;
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = wptr_q == rptr_q;
  assign push  = bus.wr && !full;
  uart_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr_q[AW-1:0]),
    .wdata (bus.wdata),
    .raddr (rptr_q[AW-1:0]),
    .rdata (rdata)
  );
  // tx_start is only ever set on the IDLE->START edge, so it is high for the START cycle alone
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: if (!empty && bus.tx_rdy) begin
        pop        = 1'b1;
        tx_data_d  = rdata;
        tx_start_d = 1'b1;
        state_d    = START;
      end
      START:   state_d = WAIT;
      WAIT:    state_d = bus.tx_rdy ? IDLE : WAIT;
      default: state_d = IDLE;
    endcase
    wptr_d = wptr_q + {{AW{1'b0}}, push};
    rptr_d = rptr_q + {{AW{1'b0}}, pop};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = wptr_q - rptr_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf_d = (bus.wr && full) || (ovf_q && !bus.ovf_clr);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end
  assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of uart_tx_fifo against a 10-cycle-frame transmitter model.
// Ovf checks are compiled in when UART_TX_FIFO_OVF_EN is defined.
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rdy_en = 1'b1;
  int         cnt = 0;
  int         n_start = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] got [$];
  logic [7:0] exp_q [$];

  uart_tx_fifo_if #(.DEPTH(16)) bus ();
  uart_tx_fifo #(.DEPTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  assign bus.tx_rdy = rdy_en && (cnt == 0);

  always @(negedge clk or negedge rst) begin
    if (!rst) cnt <= 0;
    else if (bus.tx_start) begin
      got.push_back(bus.tx_data);
      n_start <= n_start + 1;
      cnt <= 10;
    end else if (cnt > 0) cnt <= cnt - 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int n, input int limit);
    for (int i = 0; i < limit && got.size() < n; i++) tick();
    check("drain_count", got.size(), n);
  endtask

  initial begin
    int snap;
    bus.wr = 1'b0;
    bus.wdata = 8'h00;
`ifdef UART_TX_FIFO_OVF_EN
    bus.ovf_clr = 1'b0;
`endif
    #12;
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_level", bus.level, 0);
    check("rst_start", bus.tx_start, 0);
    check("rst_data", bus.tx_data, 0);
`ifdef UART_TX_FIFO_OVF_EN
    check("rst_ovf", bus.ovf, 0);
`endif
    tick();
    rst = 1'b1;
    for (int i = 0; i < 9; i++) tick();

    // single byte latency: wr in N, tx_start in N+2
    bus.wr = 1'b1; bus.wdata = 8'h55;
    tick();
    bus.wr = 1'b0;
    check("lat_n1_start", bus.tx_start, 0);
    check("lat_n1_level", bus.level, 1);
    tick();
    check("lat_n2_start", bus.tx_start, 1);
    check("lat_n2_data", bus.tx_data, 8'h55);
    tick();
    check("lat_n3_start", bus.tx_start, 0);
    check("lat_n3_empty", bus.empty, 1);
    check("lat_hold_data", bus.tx_data, 8'h55);
    for (int i = 0; i < 15; i++) tick();

    // fill to full with transmitter busy, then a dropped 17th write
    rdy_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.wr = 1'b1; bus.wdata = 8'(i);
      tick();
    end
    check("fill_full", bus.full, 1);
    check("fill_level", bus.level, 16);
    bus.wdata = 8'hAA;
    tick();
    bus.wr = 1'b0;
    check("drop_level", bus.level, 16);
    check("drop_full", bus.full, 1);
`ifdef UART_TX_FIFO_OVF_EN
    check("ovf_set", bus.ovf, 1);
    tick();
    check("ovf_sticky", bus.ovf, 1);
    bus.wr = 1'b1; bus.ovf_clr = 1'b1;
    tick();
    bus.wr = 1'b0;
    check("ovf_set_wins", bus.ovf, 1);
    tick();
    bus.ovf_clr = 1'b0;
    check("ovf_cleared", bus.ovf, 0);
`endif
    got.delete();
    rdy_en = 1'b1;
    wait_drain(16, 400);
    for (int i = 0; i < 16 && i < got.size(); i++) check($sformatf("order_%0d", i), got[i], i);
    for (int i = 0; i < 20; i++) tick();
    check("no_dup", got.size(), 16);
    check("drain_empty", bus.empty, 1);

    // 48 random bytes with continuous drain, pointers wrap three times
    got.delete();
    for (int i = 0; i < 48; i++) begin
      for (int g = 0; g < 500 && bus.full; g++) tick();
      bus.wr = 1'b1;
      bus.wdata = 8'($urandom_range(0, 255));
      exp_q.push_back(bus.wdata);
      tick();
      bus.wr = 1'b0;
    end
    wait_drain(48, 1000);
    for (int i = 0; i < 48 && i < got.size(); i++) check($sformatf("wrap_%0d", i), got[i], exp_q[i]);
    for (int i = 0; i < 15; i++) tick();

    // reset during a frame with five bytes queued
    for (int i = 0; i < 6; i++) begin
      bus.wr = 1'b1; bus.wdata = 8'h10 + 8'(i);
      tick();
    end
    bus.wr = 1'b0;
    check("pre_rst_level", bus.level, 5);
    rst = 1'b0;
    #1;
    check("mid_rst_level", bus.level, 0);
    check("mid_rst_empty", bus.empty, 1);
    check("mid_rst_start", bus.tx_start, 0);
    check("mid_rst_data", bus.tx_data, 0);
    tick(); tick();
    rst = 1'b1;
    snap = n_start;
    for (int i = 0; i < 30; i++) tick();
    check("post_rst_nostart", n_start, snap);
    check("post_rst_empty", bus.empty, 1);

    // simultaneous push and pop at level 3
    rdy_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.wr = 1'b1; bus.wdata = 8'h31 + 8'(i);
      tick();
    end
    check("pp_pre_level", bus.level, 3);
    bus.wdata = 8'h77;
    rdy_en = 1'b1;
    tick();
    bus.wr = 1'b0;
    check("pp_level", bus.level, 3);
    check("pp_start", bus.tx_start, 1);
    check("pp_data", bus.tx_data, 8'h31);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
